pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Program-counter register and fetch sequencer for the single-issue datapath. It holds the PC and
//  requests instructions from instruction memory over a req/ack handshake. It presents each fetched
//  word downstream with valid/ready and advances the PC through an INC4_32 instance. Branch/jump
//  redirects from execute override sequential flow. Sits between the redirect logic and decode.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset; must be word aligned (low 2 bits 0)
// PORTS
//  clk             in   1   system clock, all state updates on rising edge
//  reset_n         in   1   asynchronous, active-low reset
//  redirect_valid  in   1   one-cycle request to load redirect_target into PC
//  redirect_target in   32  new PC for branch/jump
//  imem_req        out  1   fetch request; held high until imem_ack
//  imem_addr       out  32  fetch address (= PC register); stable while imem_req high
//  imem_ack        in   1   memory returns imem_rdata this cycle; ignored when imem_req low
//  imem_rdata      in   32  instruction word, sampled only when imem_req & imem_ack
//  instr_valid     out  1   instr/instr_pc hold a fetched instruction
//  instr_ready     in   1   decode accepts instruction when instr_valid & instr_ready
//  instr           out  32  fetched instruction word
//  instr_pc        out  32  address the instruction was fetched from
//  misalign_err    out  1   one-cycle pulse: redirect rejected, target[1:0] != 0
//  pc_wrap         out  1   sticky: PC+4 overflowed 32 bits; cleared only by reset
// BEHAVIOUR
//  Reset (async, reset_n=0): state=BOOT, PC=RESET_VECTOR, imem_req=0, instr_valid=0, instr=0,
//   instr_pc=0, misalign_err=0, pc_wrap=0. Reset mid-request abandons it; any late ack is ignored.
//  imem_req is a Moore output: 1 in FETCH and DRAIN, else 0. imem_addr = PC at all times.
//  States / transitions (redirect = redirect_valid & target[1:0]==0):
//   BOOT  : one cycle after reset release -> FETCH (a redirect here loads PC, still -> FETCH).
//   FETCH : on ack: instr<=rdata, instr_pc<=PC, PC<=PC+4, instr_valid<=1 -> ISSUE.
//           redirect & ack same cycle: data discarded, PC<=target -> FETCH (request complete).
//           redirect without ack: PC<=target -> DRAIN (old request outstanding).
//   ISSUE : instr_valid=1, instr/instr_pc stable until accepted. On instr_ready: valid<=0 -> FETCH.
//           redirect (with or without ready): valid<=0, PC<=target -> FETCH; redirect wins.
//   DRAIN : keeps req high; PC already holds redirected target so imem_addr shows it, but the
//           returning data belongs to the old request and is discarded. On ack -> FETCH (re-issue).
//           Further redirects in DRAIN update PC, stay DRAIN.
//  Misaligned redirect in any state: ignored entirely (no state/PC change), misalign_err=1 next cycle.
//  Arithmetic: PC+4 from INC4_32; on Overflow PC wraps to 0 (32'hFFFF_FFFC -> 0), pc_wrap<=1.
//  Latency: zero-wait memory (ack same cycle as req) -> instr_valid 1 cycle after FETCH entry;
//   peak throughput one instruction per 2 cycles with instr_ready held high.
// STRUCTURE
//  Shared package/include: state encodings (BOOT, FETCH, ISSUE, DRAIN), INSTR_W=32, default reset vector.
//  One sub-module: INC4_32 (existing) for PC+4 and overflow; the rest is a single FSM + registers.
// TESTING
//  1 Reset, RESET_VECTOR=0, ack same cycle, ready=1 -> imem_addr 0,4,8; instr_pc 0,4,8 match rdata.
//  2 ack delayed 3 cycles -> imem_req high and imem_addr=0x40 stable all 4 cycles; one instr issued.
//  3 instr_ready low 5 cycles in ISSUE -> instr/instr_pc unchanged, no new imem_req until accepted.
//  4 redirect 0x100 in FETCH without ack, ack 2 cycles later -> DRAIN, stale rdata dropped, next
//    fetch addr 0x100, first issued instr_pc=0x100.
//  5 redirect target 0x102 -> misalign_err one-cycle pulse, PC and state unchanged.
//  6 redirect to 0xFFFF_FFFC, fetch acked -> next imem_addr 0, pc_wrap=1 and stays 1 until reset_n=0.

Source files
------------

// File: rtl/pc_fetch_sequencer_pkg.sv
// pc_fetch_sequencer_pkg: shared state encoding, data width and default reset vector
package pc_fetch_sequencer_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: redirect, instruction-memory and decode-side signals of the fetch sequencer
interface pc_fetch_sequencer_if;
    import pc_fetch_sequencer_pkg::*;

    logic               redirect_valid;
    logic [INSTR_W-1:0] redirect_target;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] instr_pc;
    logic               misalign_err;
    logic               pc_wrap;

    modport master (
        input  redirect_valid, redirect_target, imem_ack, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err, pc_wrap
    );

    modport slave (
        output redirect_valid, redirect_target, imem_ack, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err, pc_wrap
    );

endinterface

// File: rtl/pc_fetch_sequencer_inc4_32.sv
// inc4_32: 32-bit add-four with carry-out flagging wrap past 32'hFFFF_FFFC
module inc4_32 (
    input  logic [31:0] a,
    output logic [31:0] sum,
    output logic        overflow
);

    assign {overflow, sum} = {1'b0, a} + 33'd4;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC register and req/ack fetch FSM feeding decode over valid/ready
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pc_fetch_sequencer_if.master  bus
);

    fetch_state_t       state;
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] pc_next;
    logic               pc_ovf;
    logic               req;
    logic               vld;
    logic [INSTR_W-1:0] ins;
    logic [INSTR_W-1:0] ipc;
    logic               mis;
    logic               wrap;
    logic               aligned;
    logic               redirect;
    logic               bad_redirect;

    inc4_32 u_inc4 (
        .a        (pc),
        .sum      (pc_next),
        .overflow (pc_ovf)
    );

    assign aligned      = bus.redirect_target[1:0] == 2'b00;
    assign redirect     = bus.redirect_valid & aligned;
    assign bad_redirect = bus.redirect_valid & ~aligned;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
            pc    <= RESET_VECTOR;
            req   <= 1'b0;
            vld   <= 1'b0;
            ins   <= '0;
            ipc   <= '0;
            mis   <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            mis <= bad_redirect;
            case (state)
                BOOT: begin
                    if (redirect) pc <= bus.redirect_target;
                    state <= FETCH;
                    req   <= 1'b1;
                end
                FETCH: begin
                    // a redirect racing the ack completes the old request, so no drain is needed
                    if (redirect) begin
                        pc    <= bus.redirect_target;
                        state <= bus.imem_ack ? FETCH : DRAIN;
                    end else if (bus.imem_ack) begin
                        ins   <= bus.imem_rdata;
                        ipc   <= pc;
                        pc    <= pc_next;
                        vld   <= 1'b1;
                        req   <= 1'b0;
                        state <= ISSUE;
                        if (pc_ovf) wrap <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (redirect || bus.instr_ready) begin
                        if (redirect) pc <= bus.redirect_target;
                        vld   <= 1'b0;
                        req   <= 1'b1;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) pc <= bus.redirect_target;
                    if (bus.imem_ack) state <= FETCH;
                end
                default: begin
                    state <= BOOT;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc;
    assign bus.instr_valid  = vld;
    assign bus.instr        = ins;
    assign bus.instr_pc     = ipc;
    assign bus.misalign_err = mis;
    assign bus.pc_wrap      = wrap;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed vector table plus hand sequences for the fetch sequencer
module tb_pc_fetch_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer_if bus ();

    pc_fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        rv;
        logic [31:0] rt;
        logic        ack;
        logic [31:0] rd;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        mis;
        logic        wrap;
    } vec_t;

    vec_t vt[32];

    // Drive inputs at the falling edge, check registered outputs 1ns later, then advance one cycle.
    task automatic cyc(input string name, input logic rv, input logic [31:0] rt, input logic ack,
                       input logic [31:0] rd, input logic rdy, input logic req, input logic [31:0] addr,
                       input logic vld, input logic [31:0] ins, input logic [31:0] ipc,
                       input logic mis, input logic wrap);
        logic [99:0] got, exp;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.imem_ack        = ack;
        bus.imem_rdata      = rd;
        bus.instr_ready     = rdy;
        #1;
        got = {bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc,
               bus.misalign_err, bus.pc_wrap};
        exp = {req, addr, vld, ins, ipc, mis, wrap};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h vld=%b instr=%h pc=%h mis=%b wrap=%b, want req=%b addr=%h vld=%b instr=%h pc=%h mis=%b wrap=%b",
                     name, bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc,
                     bus.misalign_err, bus.pc_wrap, req, addr, vld, ins, ipc, mis, wrap);
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        bus.redirect_valid = 1'b0;
        bus.imem_ack       = 1'b1;
        bus.instr_ready    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc,
             bus.misalign_err, bus.pc_wrap} !== 100'd0) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h vld=%b instr=%h pc=%h mis=%b wrap=%b, want all zero",
                     name, bus.imem_req, bus.imem_addr, bus.instr_valid, bus.instr, bus.instr_pc,
                     bus.misalign_err, bus.pc_wrap);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        //          rv  target        ack rdata         rdy req addr          vld instr         instr_pc      mis wrap
        vt[0]  = '{0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        0, 32'h0,        32'h0,        0, 0};
        vt[1]  = '{0, 32'h0,        1, 32'hA000_0000,1,  1, 32'h0,        0, 32'h0,        32'h0,        0, 0};
        vt[2]  = '{0, 32'h0,        1, 32'hFFFF_FFFF,1,  0, 32'h4,        1, 32'hA000_0000,32'h0,        0, 0};
        vt[3]  = '{0, 32'h0,        1, 32'hA000_0001,1,  1, 32'h4,        0, 32'hA000_0000,32'h0,        0, 0};
        vt[4]  = '{0, 32'h0,        0, 32'h0,        1,  0, 32'h8,        1, 32'hA000_0001,32'h4,        0, 0};
        vt[5]  = '{0, 32'h0,        1, 32'hA000_0002,1,  1, 32'h8,        0, 32'hA000_0001,32'h4,        0, 0};
        vt[6]  = '{0, 32'h0,        0, 32'h0,        1,  0, 32'hC,        1, 32'hA000_0002,32'h8,        0, 0};
        vt[7]  = '{1, 32'h102,      0, 32'h0,        0,  1, 32'hC,        0, 32'hA000_0002,32'h8,        0, 0};
        vt[8]  = '{0, 32'h0,        0, 32'h0,        0,  1, 32'hC,        0, 32'hA000_0002,32'h8,        1, 0};
        vt[9]  = '{0, 32'h0,        0, 32'h0,        0,  1, 32'hC,        0, 32'hA000_0002,32'h8,        0, 0};
        vt[10] = '{1, 32'h100,      0, 32'h0,        0,  1, 32'hC,        0, 32'hA000_0002,32'h8,        0, 0};
        vt[11] = '{0, 32'h0,        0, 32'h0,        0,  1, 32'h100,      0, 32'hA000_0002,32'h8,        0, 0};
        vt[12] = '{0, 32'h0,        1, 32'hDEAD_BEEF,0,  1, 32'h100,      0, 32'hA000_0002,32'h8,        0, 0};
        vt[13] = '{0, 32'h0,        1, 32'hB000_0000,0,  1, 32'h100,      0, 32'hA000_0002,32'h8,        0, 0};
        vt[14] = '{0, 32'h0,        0, 32'h0,        1,  0, 32'h104,      1, 32'hB000_0000,32'h100,      0, 0};
        vt[15] = '{1, 32'h200,      1, 32'hBAD0_0000,0,  1, 32'h104,      0, 32'hB000_0000,32'h100,      0, 0};
        vt[16] = '{0, 32'h0,        1, 32'hC000_0000,0,  1, 32'h200,      0, 32'hB000_0000,32'h100,      0, 0};
        vt[17] = '{1, 32'h300,      0, 32'h0,        0,  0, 32'h204,      1, 32'hC000_0000,32'h200,      0, 0};
        vt[18] = '{0, 32'h0,        1, 32'hD000_0000,0,  1, 32'h300,      0, 32'hC000_0000,32'h200,      0, 0};
        vt[19] = '{1, 32'h401,      0, 32'h0,        0,  0, 32'h304,      1, 32'hD000_0000,32'h300,      0, 0};
        vt[20] = '{0, 32'h0,        0, 32'h0,        1,  0, 32'h304,      1, 32'hD000_0000,32'h300,      1, 0};
        vt[21] = '{0, 32'h0,        0, 32'h0,        0,  1, 32'h304,      0, 32'hD000_0000,32'h300,      0, 0};
        vt[22] = '{1, 32'h500,      0, 32'h0,        0,  1, 32'h304,      0, 32'hD000_0000,32'h300,      0, 0};
        vt[23] = '{1, 32'h600,      0, 32'h0,        0,  1, 32'h500,      0, 32'hD000_0000,32'h300,      0, 0};
        vt[24] = '{0, 32'h0,        1, 32'h5A5A_5A5A,0,  1, 32'h600,      0, 32'hD000_0000,32'h300,      0, 0};
        vt[25] = '{0, 32'h0,        1, 32'hE000_0000,0,  1, 32'h600,      0, 32'hD000_0000,32'h300,      0, 0};
        vt[26] = '{0, 32'h0,        0, 32'h0,        1,  0, 32'h604,      1, 32'hE000_0000,32'h600,      0, 0};
        vt[27] = '{1, 32'hFFFF_FFFC,1, 32'h1111_1111,0,  1, 32'h604,      0, 32'hE000_0000,32'h600,      0, 0};
        vt[28] = '{0, 32'h0,        1, 32'hF000_0000,0,  1, 32'hFFFF_FFFC,0, 32'hE000_0000,32'h600,      0, 0};
        vt[29] = '{0, 32'h0,        0, 32'h0,        1,  0, 32'h0,        1, 32'hF000_0000,32'hFFFF_FFFC,0, 1};
        vt[30] = '{0, 32'h0,        1, 32'hF000_0001,0,  1, 32'h0,        0, 32'hF000_0000,32'hFFFF_FFFC,0, 1};
        vt[31] = '{0, 32'h0,        0, 32'h0,        1,  0, 32'h4,        1, 32'hF000_0001,32'h0,        0, 1};

        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
        bus.instr_ready     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++)
            cyc($sformatf("vec%0d", i), vt[i].rv, vt[i].rt, vt[i].ack, vt[i].rd, vt[i].rdy,
                vt[i].req, vt[i].addr, vt[i].vld, vt[i].ins, vt[i].ipc, vt[i].mis, vt[i].wrap);

        // reset mid-request with ack held high: late ack must not produce an instruction
        do_reset("reset_mid_fetch");
        cyc("boot_late_ack", 0, 0, 1, 32'hBAD1_BAD1, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        cyc("boot_to_fetch", 0, 0, 0, 32'h0,        0, 1, 32'h0, 0, 32'h0, 32'h0, 0, 0);

        // redirect taken in BOOT, then an ack delayed three cycles
        do_reset("reset_again");
        cyc("boot_redirect", 1, 32'h40, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++)
            cyc($sformatf("ack_wait%0d", k), 0, 0, 0, 32'h0, 0, 1, 32'h40, 0, 32'h0, 32'h0, 0, 0);
        cyc("ack_late", 0, 0, 1, 32'h1234_5678, 0, 1, 32'h40, 0, 32'h0, 32'h0, 0, 0);

        // decode stalls five cycles; stray acks while not requesting are ignored
        for (int k = 0; k < 5; k++)
            cyc($sformatf("stall%0d", k), 0, 0, 1, 32'h9999_9999, 0,
                0, 32'h44, 1, 32'h1234_5678, 32'h40, 0, 0);
        cyc("accept", 0, 0, 0, 32'h0, 1, 0, 32'h44, 1, 32'h1234_5678, 32'h40, 0, 0);
        cyc("refetch", 0, 0, 0, 32'h0, 0, 1, 32'h44, 0, 32'h1234_5678, 32'h40, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
